// File: rtl/rm_hdr_param.sv
// ---------------------------------------------------------------------------
// rm_hdr_param -- parametrised module-header stripper for the egress edge of
// the NetFPGA user data path.
//
// A header word is any word with nonzero ctrl seen between packets (before a
// packet's first data word). Header words are discarded, except those whose
// ctrl equals KEEP_HDR_CTRL (when that parameter is nonzero). Data words and
// the EOP word of each packet are buffered in an internal FIFO and emitted
// through a registered output stage.
//
// Parameters:
//   DATA_WIDTH    data bus width in bits
//   CTRL_WIDTH    ctrl bus width in bits
//   FIFO_DEPTH    buffer depth in words (power of 2, >= 4)
//   AF_MARGIN     in_rdy drops when free slots <= AF_MARGIN
//   KEEP_HDR_CTRL header ctrl value to retain (0 = strip every header)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr      ingress word and its valid strobe
//   in_rdy                     upstream may write next cycle
//   out_data/out_ctrl/out_wr   egress word and its valid strobe
//   out_rdy                    downstream may accept a word
//   overflow                   sticky: a store was attempted while full
//
// Optional build macro RM_HDR_PARAM_STATS_EN adds:
//   clear_stats                synchronous clear of the counters below
//   hdr_dropped_cnt            discarded header words   (saturating)
//   pkt_cnt                    stored EOP words         (saturating)
//   drop_full_cnt              words lost to a full FIFO (saturating)
// The datapath is identical with or without the macro.
// ---------------------------------------------------------------------------
module rm_hdr_param #(
    parameter int                    DATA_WIDTH    = 64,
    parameter int                    CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int                    FIFO_DEPTH    = 16,
    parameter int                    AF_MARGIN     = 3,
    parameter logic [CTRL_WIDTH-1:0] KEEP_HDR_CTRL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
`ifdef RM_HDR_PARAM_STATS_EN
    input  logic                  clear_stats,
    output logic [31:0]           hdr_dropped_cnt,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_full_cnt,
`endif
    output logic                  overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = CTRL_WIDTH + DATA_WIDTH;

    localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] MARGIN_P = PW'(AF_MARGIN);

    typedef enum logic {
        ST_HDR    = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    state_t                  state_q;
    state_t                  state_d;

    logic [WW-1:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [PW-1:0]           count;
    logic [PW-1:0]           free_slots;
    logic                    empty;
    logic                    full;

    logic                    ctrl_zero;
    logic                    keep_match;
    logic                    store;
    logic                    rd_en;
    logic                    wr_en;
    logic                    lost;

    logic                    in_rdy_q;
    logic                    out_wr_q;
    logic                    overflow_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [CTRL_WIDTH-1:0]   out_ctrl_q;

    // -----------------------------------------------------------------------
    // Ingress classification
    // -----------------------------------------------------------------------
    assign ctrl_zero = (in_ctrl == '0);

    // With KEEP_HDR_CTRL == 0 no header is ever retained, so the comparator
    // is not built at all (a zero-ctrl word is a data word, never a header).
    generate
        if (KEEP_HDR_CTRL != '0) begin : g_keep
            assign keep_match = (in_ctrl == KEEP_HDR_CTRL);
        end else begin : g_strip_all
            assign keep_match = 1'b0;
        end
    endgenerate

    assign store = in_wr && ((state_q == ST_IN_PKT) || ctrl_zero || keep_match);

    // -----------------------------------------------------------------------
    // FIFO status. Pointers carry one extra wrap bit so full and empty are
    // distinguishable; the difference is the fill count modulo 2^PW.
    // -----------------------------------------------------------------------
    assign count      = wr_ptr_q - rd_ptr_q;
    assign free_slots = DEPTH_P - count;
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = out_rdy && !empty;
    // A read in the same cycle frees the head slot, so a store into a full
    // FIFO is still accepted then; the read port sees the old head value.
    assign wr_en = store && (!full || rd_en);
    assign lost  = store && full && !rd_en;

    // -----------------------------------------------------------------------
    // Next state: advances on every ingress word, stored or not. A kept
    // header arrives with nonzero ctrl in ST_HDR and therefore stays there.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (in_wr) begin
            case (state_q)
                ST_HDR:    if (ctrl_zero)  state_d = ST_IN_PKT;
                ST_IN_PKT: if (!ctrl_zero) state_d = ST_HDR;
                default:   state_d = ST_HDR;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control registers: state, pointers, flags and registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_rdy_q   <= 1'b1;
            out_wr_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_wr_q <= rd_en;
            // Derived from the count before this cycle's update; the one
            // cycle of lag is covered by AF_MARGIN.
            in_rdy_q <= (free_slots > MARGIN_P);
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (lost) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array: write port only, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {in_ctrl, in_data};
        end
    end

    // Registered read port doubling as the output stage. It only loads on a
    // read, so the egress bus holds its last word while out_wr is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q <= '0;
            out_ctrl_q <= '0;
        end else if (rd_en) begin
            {out_ctrl_q, out_data_q} <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign in_rdy   = in_rdy_q;
    assign out_wr   = out_wr_q;
    assign out_data = out_data_q;
    assign out_ctrl = out_ctrl_q;
    assign overflow = overflow_q;

`ifdef RM_HDR_PARAM_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics counters. Each saturates at all-ones; clear wins over a
    // simultaneous increment.
    // -----------------------------------------------------------------------
    localparam int NUM_STATS = 3;

    logic [NUM_STATS-1:0] stat_inc;
    logic [31:0]          stat_q [NUM_STATS];

    // A discarded header is any ingress word the store rule rejects.
    assign stat_inc[0] = in_wr && !store;
    // Only an EOP that actually reaches the FIFO counts as a packet.
    assign stat_inc[1] = wr_en && (state_q == ST_IN_PKT) && !ctrl_zero;
    assign stat_inc[2] = lost;

    generate
        for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_stat
            always_ff @(posedge clk) begin
                if (reset || clear_stats) begin
                    stat_q[gi] <= '0;
                end else if (stat_inc[gi] && (stat_q[gi] != '1)) begin
                    stat_q[gi] <= stat_q[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign hdr_dropped_cnt = stat_q[0];
    assign pkt_cnt         = stat_q[1];
    assign drop_full_cnt   = stat_q[2];
`endif

endmodule

// File: tb/tb_rm_hdr_param.sv
// ---------------------------------------------------------------------------
// Testbench for rm_hdr_param. Two instances share the ingress stimulus:
//   dut_a strips every header (KEEP_HDR_CTRL = 0)
//   dut_b retains headers with ctrl 8'hFF
// Each instance has its own scoreboard queue of expected egress words.
// ---------------------------------------------------------------------------
module tb_rm_hdr_param;

    localparam int DW = 64;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset   = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_wr   = 1'b0;
    logic          out_rdy = 1'b0;

    logic          in_rdy_a, out_wr_a, overflow_a;
    logic [DW-1:0] out_data_a;
    logic [CW-1:0] out_ctrl_a;
    logic          in_rdy_b, out_wr_b, overflow_b;
    logic [DW-1:0] out_data_b;
    logic [CW-1:0] out_ctrl_b;

`ifdef RM_HDR_PARAM_STATS_EN
    logic        clear_stats = 1'b0;
    logic [31:0] hdr_a, pkt_a, dfull_a;
    logic [31:0] hdr_b, pkt_b, dfull_b;
`endif

    int checks = 0;
    int errors = 0;

    logic [CW+DW-1:0] q_a[$];
    logic [CW+DW-1:0] q_b[$];
    logic [CW+DW-1:0] exp_a;
    logic [CW+DW-1:0] exp_b;

    rm_hdr_param #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH(16), .AF_MARGIN(3),
        .KEEP_HDR_CTRL(8'h00)
    ) dut_a (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy_a),
        .out_data(out_data_a), .out_ctrl(out_ctrl_a), .out_wr(out_wr_a),
        .out_rdy(out_rdy),
`ifdef RM_HDR_PARAM_STATS_EN
        .clear_stats(clear_stats), .hdr_dropped_cnt(hdr_a), .pkt_cnt(pkt_a),
        .drop_full_cnt(dfull_a),
`endif
        .overflow(overflow_a)
    );

    rm_hdr_param #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH(16), .AF_MARGIN(3),
        .KEEP_HDR_CTRL(8'hFF)
    ) dut_b (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy_b),
        .out_data(out_data_b), .out_ctrl(out_ctrl_b), .out_wr(out_wr_b),
        .out_rdy(out_rdy),
`ifdef RM_HDR_PARAM_STATS_EN
        .clear_stats(clear_stats), .hdr_dropped_cnt(hdr_b), .pkt_cnt(pkt_b),
        .drop_full_cnt(dfull_b),
`endif
        .overflow(overflow_b)
    );

    // ---------------------------------------------------------------------
    // Egress monitors: every out_wr pops and compares one expected word.
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        if (out_wr_a) begin
            checks++;
            assert (q_a.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out_a: out_wr=1 data=%0h with no word expected", out_data_a);
            end
            if (q_a.size() != 0) begin
                exp_a = q_a.pop_front();
                checks++;
                assert ({out_ctrl_a, out_data_a} === exp_a) else begin
                    errors++;
                    $error("FAIL out_word_a: observed %0h expected %0h", {out_ctrl_a, out_data_a}, exp_a);
                end
                $display("out_a ctrl=%02h data=%016h", out_ctrl_a, out_data_a);
            end
        end
        if (out_wr_b) begin
            checks++;
            assert (q_b.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out_b: out_wr=1 data=%0h with no word expected", out_data_b);
            end
            if (q_b.size() != 0) begin
                exp_b = q_b.pop_front();
                checks++;
                assert ({out_ctrl_b, out_data_b} === exp_b) else begin
                    errors++;
                    $error("FAIL out_word_b: observed %0h expected %0h", {out_ctrl_b, out_data_b}, exp_b);
                end
                $display("out_b ctrl=%02h data=%016h", out_ctrl_b, out_data_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    task automatic chk(input string tag, input logic [CW+DW-1:0] obs, input logic [CW+DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one word for one clock; pa/pb say whether each instance keeps it.
    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input bit pa, input bit pb);
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
        if (pa) q_a.push_back({c, d});
        if (pb) q_b.push_back({c, d});
        @(posedge clk);
        #1;
        in_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for in_rdy while toggling out_rdy, then send a data word.
    task automatic send_flow(input logic [CW-1:0] c, input logic [DW-1:0] d);
        int w;
        w = 0;
        while (!in_rdy_a && (w < 200)) begin
            out_rdy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 200) chk("in_rdy_timeout", in_rdy_a, 1'b1);
        out_rdy = 1'($urandom_range(0, 1));
        send(c, d, 1'b1, 1'b1);
    endtask

    task automatic drain;
        out_rdy = 1'b1;
        idle(40);
        chk("q_a_empty", q_a.size(), 0);
        chk("q_b_empty", q_b.size(), 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        in_wr = 1'b0;
        @(posedge clk);
        #1;
        q_a.delete();
        q_b.delete();
        reset = 1'b0;
    endtask

`ifdef RM_HDR_PARAM_STATS_EN
    task automatic pulse_clear;
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
    endtask
`endif

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        // Reset values, sampled while reset is held and just after release.
        idle(3);
        @(negedge clk);
        chk("rst_out_wr",   out_wr_a,   1'b0);
        chk("rst_out_data", out_data_a, '0);
        chk("rst_out_ctrl", out_ctrl_a, '0);
        chk("rst_overflow", overflow_a, 1'b0);
        chk("rst_in_rdy",   in_rdy_a,   1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_wr", out_wr_b, 1'b0);
        chk("post_rst_in_rdy", in_rdy_b, 1'b1);

        // Strip headers; dut_b keeps the FF header.
        out_rdy = 1'b1;
        send(8'hFF, 64'hAAAA_0000_0000_0000, 1'b0, 1'b1);
        send(8'h00, 64'hD000_0000_0000_0000, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_n1_out_wr", out_wr_a, 1'b0);
        send(8'h00, 64'hD000_0000_0000_0001, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_n2_out_wr", out_wr_a, 1'b1);
        chk("lat_n2_data",   out_data_a, 64'hD000_0000_0000_0000);
        send(8'h80, 64'hD000_0000_0000_0002, 1'b1, 1'b1);
        drain();
        // Bus holds the EOP word once out_wr drops.
        chk("hold_ctrl", out_ctrl_a, 8'h80);

        // Keep one header type.
`ifdef RM_HDR_PARAM_STATS_EN
        pulse_clear();
`endif
        send(8'hFF, 64'h4000_0000_0000_0000, 1'b0, 1'b1);
        send(8'h40, 64'h4000_0000_0000_0001, 1'b0, 1'b0);
        send(8'h00, 64'h4000_0000_0000_0002, 1'b1, 1'b1);
        send(8'h01, 64'h4000_0000_0000_0003, 1'b1, 1'b1);
        drain();
`ifdef RM_HDR_PARAM_STATS_EN
        chk("hdr_drop_a", hdr_a, 32'd2);
        chk("hdr_drop_b", hdr_b, 32'd1);
        chk("pkt_cnt_a",  pkt_a, 32'd1);
        chk("pkt_cnt_b",  pkt_b, 32'd1);
`endif

        // Backpressure: in_rdy falls once 13 words are buffered.
        out_rdy = 1'b0;
        for (int i = 0; i < 12; i++) send(8'h00, 64'hB000_0000_0000_0000 + 64'(i), 1'b1, 1'b1);
        idle(2);
        chk("in_rdy_at_12", in_rdy_a, 1'b1);
        send(8'h00, 64'hB000_0000_0000_000C, 1'b1, 1'b1);
        idle(2);
        chk("in_rdy_at_13", in_rdy_a, 1'b0);
        send(8'h00, 64'hB000_0000_0000_000D, 1'b1, 1'b1);
        send(8'h00, 64'hB000_0000_0000_000E, 1'b1, 1'b1);
        chk("bp_overflow_a", overflow_a, 1'b0);
        chk("bp_overflow_b", overflow_b, 1'b0);
        drain();
        chk("in_rdy_drained", in_rdy_a, 1'b1);

        // Overflow: 16 words fit, the next 4 are lost (last one is the EOP).
`ifdef RM_HDR_PARAM_STATS_EN
        pulse_clear();
`endif
        out_rdy = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h00, 64'hC000_0000_0000_0000 + 64'(i), 1'b1, 1'b1);
        chk("full_no_overflow", overflow_a, 1'b0);
        for (int i = 16; i < 19; i++) send(8'h00, 64'hC000_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
        send(8'h80, 64'hC000_0000_0000_0013, 1'b0, 1'b0);
        chk("overflow_set", overflow_a, 1'b1);
`ifdef RM_HDR_PARAM_STATS_EN
        chk("drop_full_a", dfull_a, 32'd4);
        chk("pkt_lost_eop", pkt_a, 32'd0);
`endif
        drain();
        chk("overflow_sticky", overflow_a, 1'b1);

        // Pointer wrap under random backpressure.
        do_reset();
        @(negedge clk);
        chk("overflow_cleared", overflow_a, 1'b0);
        for (int p = 0; p < 100; p++) begin
            send_flow(8'h00, {32'(p), 32'h0000_0000});
            send_flow(8'h00, {32'(p), 32'h0000_0001});
            send_flow(8'h80, {32'(p), 32'h0000_0002});
        end
        drain();
        chk("wrap_overflow", overflow_b, 1'b0);

        // Mid-packet reset flushes buffered words.
        out_rdy = 1'b0;
        send(8'h00, 64'hE000_0000_0000_0000, 1'b0, 1'b0);
        send(8'h00, 64'hE000_0000_0000_0001, 1'b0, 1'b0);
        do_reset();
        @(negedge clk);
        chk("midrst_out_wr", out_wr_a, 1'b0);
        chk("midrst_in_rdy", in_rdy_a, 1'b1);
        out_rdy = 1'b1;
        idle(4);
        send(8'hFF, 64'hF000_0000_0000_0000, 1'b0, 1'b1);
        send(8'h00, 64'hF000_0000_0000_0001, 1'b1, 1'b1);
        send(8'h00, 64'hF000_0000_0000_0002, 1'b1, 1'b1);
        send(8'h80, 64'hF000_0000_0000_0003, 1'b1, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rm_hdr_param.md
Name: rm_hdr_param

Overview:
- Parametrised header stripper for the NetFPGA module pipeline.
- Removes module-header words from each packet before egress. A header word is a word with nonzero ctrl seen before a packet's first data word.
- Optionally retains one selected header type, identified by its ctrl value.
- Buffers words in an internal configurable-depth FIFO, with in_rdy backpressure and a registered output stage.
- Sits at the egress edge of the user data path, ahead of the MAC/CPU output queues.

Parameters:
- DATA_WIDTH, 64, data bus width in bits.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width in bits.
- FIFO_DEPTH, 16, buffer depth in words; power of 2, minimum 4.
- AF_MARGIN, 3, in_rdy deasserts when free slots <= AF_MARGIN; 1 <= AF_MARGIN < FIFO_DEPTH.
- KEEP_HDR_CTRL, 0, header ctrl value to retain; 0 means strip all headers.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  ingress data.
- in_ctrl  in  CTRL_WIDTH  ingress ctrl; nonzero = header word, or EOP while in packet.
- in_wr  in  1  ingress word valid.
- in_rdy  out  1  ingress may write next cycle.
- out_data  out  DATA_WIDTH  egress data.
- out_ctrl  out  CTRL_WIDTH  egress ctrl.
- out_wr  out  1  egress word valid.
- out_rdy  in  1  downstream may accept.
- overflow  out  1  sticky: word written while FIFO full.

Behaviour:
- Clocking/reset: single clock clk; reset is synchronous and active-high.
- Values during reset and on the first cycle after it:
  - out_wr=0, out_data=0, out_ctrl=0, overflow=0, in_rdy=1.
  - FIFO empty, state=HDR.
- State machine, advanced only on in_wr:
  - HDR (between packets): in_ctrl==0 -> IN_PKT; word stored. in_ctrl!=0 -> stay in HDR.
  - IN_PKT: in_ctrl!=0 is the EOP word -> HDR; word stored. in_ctrl==0 -> stay; word stored.
- Store rule: in_wr && (state==IN_PKT || in_ctrl==0 || (KEEP_HDR_CTRL!=0 && in_ctrl==KEEP_HDR_CTRL)).
- All other header words in HDR are discarded.
- A kept header word does not change state.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full when the pointer MSBs differ and the lower bits are equal.
  - Fill count = wr_ptr - rd_ptr, modulo 2^(log2(FIFO_DEPTH)+1).
- Simultaneous store and read in the same cycle: count unchanged; legal when full.
- in_rdy = (FIFO_DEPTH - count) > AF_MARGIN, registered from the current-cycle count.
- Upstream may issue up to AF_MARGIN-1 writes after in_rdy falls without loss.
- Store attempted while full and no read in the same cycle:
  - Word dropped.
  - overflow set; it clears only on reset.
  - State still advances per the state machine.
- Read side:
  - rd_en = out_rdy && !empty.
  - out_data/out_ctrl register the FIFO head on rd_en; out_wr <= rd_en.
  - Data and out_wr are valid in the same cycle, one cycle after rd_en.
  - out_data/out_ctrl hold their last value when out_wr=0.
- Latency: a word stored in cycle N appears at the earliest with out_wr in cycle N+2, when the FIFO was empty and out_rdy=1.
- Ordering preserved; no reordering, duplication or gaps within the stored stream.
- Reset mid-packet: FIFO flushed, state=HDR. Residual upstream data words resume a new packet, because they have ctrl==0.

Optional Feature:
- Macro: RM_HDR_PARAM_STATS_EN.
- Defined: adds three outputs, each 32 bits, all clear on reset and on a new clear_stats input (1-bit, synchronous):
  - hdr_dropped_cnt: +1 per discarded header word.
  - pkt_cnt: +1 per stored EOP word.
  - drop_full_cnt: +1 per word lost to overflow.
  - All counters saturate at 0xFFFFFFFF.
  - clear_stats wins over a simultaneous increment.
- Undefined: the ports and counters are absent. Datapath behaviour is identical in both builds.

Test Plan:
- Strip headers: KEEP_HDR_CTRL=0, out_rdy=1. Send ctrl FF (hdr), data D0, D1, ctrl 0x80 EOP D2. Expect exactly D0, D1, D2 out; out_ctrl 00, 00, 80; D0 out_wr 2 cycles after its in_wr.
- Keep one header type: KEEP_HDR_CTRL=8'hFF. Send FF:H0, 0x40:H1, D0, 0x01:D1. Expect H0(ctrl FF), D0, D1 out; H1 dropped; with stats, hdr_dropped_cnt=1 and pkt_cnt=1.
- Backpressure: FIFO_DEPTH=16, AF_MARGIN=3, out_rdy=0. Stream data words. Expect in_rdy=0 after 13 stored words; 2 further writes accepted; overflow stays 0. Raising out_rdy drains all 15 words in order.
- Overflow: continue writing past full with out_rdy=0. Expect overflow=1 and sticky; excess words absent from the output; with stats, drop_full_cnt equals the number of lost words.
- Pointer wrap: 100 back-to-back packets of 3 words, out_rdy toggling with a 50% pseudo-random pattern. Expect output identical to the stored stream and no spurious out_wr.
- Mid-packet reset: assert reset for 1 cycle after the 2nd data word. Expect out_wr=0 and FIFO empty the next cycle. A following FF header is stripped; the next data packet passes intact.
